// File: rtl/fpr_cdb_arbiter.sv
// FPR common-data-bus arbiter: grants one FP unit per cycle and broadcasts its tag/result one cycle later.
// Define FPR_CDB_RR_EN for rotating round-robin priority; otherwise fixed priority with index 0 highest.

`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

package fpr_cdb_pkg;
  localparam int ROB_WIDTH = `ROB_WIDTH;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;
endpackage

module fpr_cdb_arbiter
  import fpr_cdb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][ROB_WIDTH-1:0]    req_tag,
  input  logic [N_REQ-1:0][31:0]             req_result,
  output cdb_t                               fpr_cdb,
  output logic [15:0]                        grant_count
);

  localparam int SELW = $clog2(N_REQ);

  logic [SELW-1:0]      w_ptr;
  logic                 w_found;
  logic                 w_grant;
  logic [SELW-1:0]      w_sel;
  logic [N_REQ-1:0]     w_ready;

  logic                 r_any;
  logic [SELW-1:0]      r_sel;
  logic [ROB_WIDTH-1:0] r_tag;
  logic [15:0]          r_count;

`ifdef FPR_CDB_RR_EN
  logic [SELW-1:0]      r_ptr;

  assign w_ptr = r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_sel == SELW'(N_REQ-1)) ? '0 : w_sel + 1'b1;
    end
  end
`else
  assign w_ptr = '0;
`endif

  // Scan from the priority pointer upward, wrapping; first requester wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(w_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!w_found && req_valid[SELW'(idx)]) begin
        w_found = 1'b1;
        w_sel   = SELW'(idx);
      end
    end
  end

  assign w_grant = w_found && !reset;

  always_comb begin
    w_ready = '0;
    if (w_grant) begin
      w_ready[w_sel] = 1'b1;
    end
  end

  assign req_ready = w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_any   <= 1'b0;
      r_sel   <= '0;
      r_tag   <= '0;
      r_count <= '0;
    end else begin
      r_any <= w_grant;
      r_sel <= w_sel;
      r_tag <= req_tag[w_sel];
      if (w_grant && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  // The winner registers its result on the grant edge, so data is muxed live from it here.
  assign fpr_cdb.valid = r_any;
  assign fpr_cdb.tag   = r_any ? r_tag : '0;
  assign fpr_cdb.data  = r_any ? req_result[r_sel] : 32'd0;
  assign grant_count   = r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(req_ready));
      assert ((req_ready & ~req_valid) == '0);
    end
  end

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Directed self-checking bench for fpr_cdb_arbiter; expectations follow FPR_CDB_RR_EN if defined.

module tb_fpr_cdb_arbiter;
  import fpr_cdb_pkg::*;

  localparam int RW = fpr_cdb_pkg::ROB_WIDTH;

`ifdef FPR_CDB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic [3:0]           reqValid;
  logic [3:0]           reqReady;
  logic [3:0][RW-1:0]   reqTag;
  logic [3:0][31:0]     reqResult;
  cdb_t                 fprCdb;
  logic [15:0]          grantCount;

  int checks;
  int failures;

  cdb_t expCdb;
  int   grantIdx;

  fpr_cdb_arbiter #(.N_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_tag    (reqTag),
    .req_result (reqResult),
    .fpr_cdb    (fprCdb),
    .grant_count(grantCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] valid);
    @(negedge clk);
    reset    = rst;
    reqValid = valid;
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    reqValid  = '0;
    reqTag    = '0;
    reqResult = '0;

    // Reset state, including ready forced low while requests are present.
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b1111);
    checkOutput("reset_ready", 64'(reqReady), 64'(4'b0000));
    checkOutput("reset_cdb", 64'(fprCdb), 64'd0);
    checkOutput("reset_count", 64'(grantCount), 64'd0);

    // Single request from unit 2.
    reqTag[2] = RW'(4'hA);
    applyStimulus(1'b0, 4'b0100);
    checkOutput("single_ready", 64'(reqReady), 64'(4'b0100));
    reqResult[2] = 32'h3F800000;
    applyStimulus(1'b0, 4'b0000);
    expCdb = '{valid: 1'b1, tag: RW'(4'hA), data: 32'h3F800000};
    checkOutput("single_cdb", 64'(fprCdb), 64'(expCdb));
    checkOutput("single_count", 64'(grantCount), 64'd1);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("single_after_cdb", 64'(fprCdb), 64'd0);

    // All four requesting for 8 cycles from a fresh reset.
    for (int i = 0; i < 4; i++) begin
      reqTag[i]    = RW'(i + 8);
      reqResult[i] = 32'h1000 + 32'(i);
    end
    applyStimulus(1'b1, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 4'b1111);
      grantIdx = RR ? (k % 4) : 0;
      checkOutput($sformatf("all_ready_%0d", k), 64'(reqReady), 64'(4'b0001 << grantIdx));
      if (k > 0) begin
        grantIdx = RR ? ((k - 1) % 4) : 0;
        expCdb = '{valid: 1'b1, tag: RW'(grantIdx + 8), data: 32'h1000 + 32'(grantIdx)};
        checkOutput($sformatf("all_cdb_%0d", k), 64'(fprCdb), 64'(expCdb));
      end
    end
    applyStimulus(1'b0, 4'b0000);
    grantIdx = RR ? 3 : 0;
    expCdb = '{valid: 1'b1, tag: RW'(grantIdx + 8), data: 32'h1000 + 32'(grantIdx)};
    checkOutput("all_cdb_last", 64'(fprCdb), 64'(expCdb));
    checkOutput("all_count", 64'(grantCount), 64'd8);

    // Rotation skip with requests on units 0 and 3.
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("skip_ready0", 64'(reqReady), 64'(4'b0001));
    applyStimulus(1'b0, 4'b1001);
    checkOutput("skip_ready1", 64'(reqReady), 64'(RR ? 4'b1000 : 4'b0001));
    applyStimulus(1'b0, 4'b1001);
    checkOutput("skip_ready2", 64'(reqReady), 64'(4'b0001));
    applyStimulus(1'b0, 4'b1001);
    checkOutput("skip_ready3", 64'(reqReady), 64'(RR ? 4'b1000 : 4'b0001));

    // Reset arriving together with a request from unit 1.
    reqTag[1] = RW'(4'h5);
    applyStimulus(1'b1, 4'b0010);
    checkOutput("midrst_ready", 64'(reqReady), 64'(4'b0000));
    applyStimulus(1'b0, 4'b1111);
    checkOutput("midrst_cdb", 64'(fprCdb), 64'd0);
    checkOutput("midrst_count", 64'(grantCount), 64'd0);
    checkOutput("midrst_ptr_ready", 64'(reqReady), 64'(4'b0001));

    // Idle: nothing granted, bus quiet, pointer and count hold.
    applyStimulus(1'b0, 4'b0000);
    checkOutput("idle_drain_count", 64'(grantCount), 64'd1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'b0000);
      checkOutput($sformatf("idle_ready_%0d", k), 64'(reqReady), 64'(4'b0000));
      checkOutput($sformatf("idle_cdb_%0d", k), 64'(fprCdb), 64'd0);
    end
    applyStimulus(1'b0, 4'b1111);
    checkOutput("idle_count", 64'(grantCount), 64'd1);
    checkOutput("idle_ptr_ready", 64'(reqReady), 64'(RR ? 4'b0010 : 4'b0001));

    // Saturation of the grant counter.
    for (int k = 0; k < 65540; k++) begin
      applyStimulus(1'b0, 4'b1111);
    end
    checkOutput("sat_count", 64'(grantCount), 64'(16'hFFFF));
    applyStimulus(1'b0, 4'b1111);
    checkOutput("sat_hold_busy", 64'(grantCount), 64'(16'hFFFF));
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
    checkOutput("sat_hold_idle", 64'(grantCount), 64'(16'hFFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
